// File: rtl/tune_trigger.sv
// Request front-end for the piezo tune player: debounced button plus tour-done
// pulses become single-cycle go strobes, with one coalesced replay during a tune.
module tune_trigger #(
  parameter bit          FAST_SIM = 1'b1,
  parameter int unsigned DEB_CYC  = FAST_SIM ? 16 : 65536,
  parameter int unsigned LOCK_CYC = FAST_SIM ? 4194320 : 67108880
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       tour_done,
  output logic       go,
  output logic       busy,
  output logic       pending,
  output logic [3:0] drop_cnt
);

  localparam int unsigned DEB_W  = $clog2(DEB_CYC);
  localparam int unsigned LOCK_W = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t              state;
  logic                btn_m;
  logic                btn_s;
  logic                btn_db;
  logic                btn_db_q;
  logic [DEB_W-1:0]    deb_cnt;
  logic [LOCK_W-1:0]   lock_cnt;
  logic                req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  // btn_db follows btn_s only after DEB_CYC consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_s == btn_db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
        btn_db  <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  assign req  = (btn_db & ~btn_db_q) | tour_done;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      go       <= 1'b0;
      pending  <= 1'b0;
      drop_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          go <= 1'b0;
          if (req) state <= FIRE;
        end
        FIRE: begin
          go       <= 1'b1;
          lock_cnt <= LOCK_W'(LOCK_CYC - 1);
          state    <= LOCK;
          if (req) begin
            if (!pending)                pending  <= 1'b1;
            else if (drop_cnt != 4'hF)   drop_cnt <= drop_cnt + 4'd1;
          end
        end
        LOCK: begin
          go <= 1'b0;
          // a request landing on the final lockout cycle refires directly
          if (lock_cnt == '0) begin
            if (pending || req) begin
              pending <= 1'b0;
              state   <= FIRE;
            end else begin
              state <= IDLE;
            end
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
            if (req) begin
              if (!pending)              pending  <= 1'b1;
              else if (drop_cnt != 4'hF) drop_cnt <= drop_cnt + 4'd1;
            end
          end
        end
        default: begin
          go    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tune_trigger.sv
// Scoreboard bench for tune_trigger with a shortened lockout.
module tb_tune_trigger;

  localparam int L = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       tour_done;
  logic       go;
  logic       busy;
  logic       pending;
  logic [3:0] drop_cnt;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int sb[$];

  tune_trigger #(.FAST_SIM(1'b1), .LOCK_CYC(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .tour_done (tour_done),
    .go        (go),
    .busy      (busy),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    nchecks++;
    if (obs != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // every go cycle must match the next expected go time
  always @(negedge clk) begin
    if (go) begin
      if (sb.size() == 0) check("go_unexpected", go, 0);
      else                check("go_cycle", cyc, sb.pop_front());
    end
  end

  task automatic pulse();
    tour_done = 1'b1;
    @(negedge clk);
    tour_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 4 * L + 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    btn = 1'b0;
    tour_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pending, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // single tour_done in IDLE
    c = cyc;
    sb.push_back(c + 2);
    pulse();
    check("t1_busy_start", busy, 1);
    wait_idle("t1");
    check("t1_busy_end", cyc, c + 1 + (L + 1));
    repeat (5) @(negedge clk);

    // bouncy press, then bouncy release
    for (int i = 0; i < 20; i++) begin
      btn = (i % 2 == 0);
      repeat (5) @(negedge clk);
    end
    c = cyc;
    btn = 1'b1;
    sb.push_back(c + 20);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 1);
      repeat (5) @(negedge clk);
    end
    btn = 1'b0;
    repeat (40) @(negedge clk);
    wait_idle("t2");
    check("t2_pending", pending, 0);
    repeat (5) @(negedge clk);

    // three requests during lockout: one queued, two dropped
    c = cyc;
    sb.push_back(c + 2);
    sb.push_back(c + 2 + L + 1);
    pulse();
    for (int i = 0; i < 3; i++) begin
      repeat (10) @(negedge clk);
      pulse();
    end
    check("t3_pending", pending, 1);
    check("t3_drop", drop_cnt, 2);
    wait_idle("t3");
    check("t3_busy_end", cyc, c + 1 + 2 * (L + 1));
    check("t3_pending_end", pending, 0);

    // debounced rise coincident with tour_done
    do_reset();
    check("t4_drop_rst", drop_cnt, 0);
    c = cyc;
    btn = 1'b1;
    repeat (18) @(negedge clk);
    tour_done = 1'b1;
    sb.push_back(c + 20);
    @(negedge clk);
    tour_done = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_pending", pending, 0);
    check("t4_drop", drop_cnt, 0);
    btn = 1'b0;
    wait_idle("t4");
    repeat (30) @(negedge clk);

    // tour_done on the final lockout cycle refires
    c = cyc;
    sb.push_back(c + 2);
    pulse();
    repeat (L) @(negedge clk);
    sb.push_back(c + L + 3);
    pulse();
    check("t5_pending", pending, 0);
    check("t5_drop", drop_cnt, 0);
    wait_idle("t5");
    check("t5_busy_end", cyc, c + 1 + 2 * (L + 1));
    repeat (5) @(negedge clk);

    // overflow saturation, then reset mid-lockout
    c = cyc;
    sb.push_back(c + 2);
    pulse();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      pulse();
      @(negedge clk);
    end
    check("t6_pending", pending, 1);
    check("t6_drop_sat", drop_cnt, 15);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_go", go, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (L + 50) @(negedge clk);
    check("t6_quiet_busy", busy, 0);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
